// File: rtl/game_pkg.sv
// Shared game constants: one-hot game states, referee FSM encodings and round defaults.
package game_pkg;

  localparam logic [5:0] INI    = 6'b000001;
  localparam logic [5:0] FIRST  = 6'b000010;
  localparam logic [5:0] SECOND = 6'b000100;
  localparam logic [5:0] THIRD  = 6'b001000;
  localparam logic [5:0] FIN    = 6'b010000;
  localparam logic [5:0] WIN    = 6'b100000;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [9:0] GOAL_X_DEF       = 10'd600;
  localparam logic [2:0] HOLD_FRAMES_DEF  = 3'd4;
  localparam logic [7:0] ROUND_FRAMES_DEF = 8'd180;

  function automatic logic is_round_state(input logic [5:0] s);
    return (s == FIRST) || (s == SECOND) || (s == THIRD) || (s == FIN);
  endfunction

endpackage

// File: rtl/round_timer.sv
// Per-round frame budget: loadable, saturating 8-bit down counter with an expired flag.
module round_timer #(
  parameter logic [7:0] INIT = 8'd180
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       load,
  input  logic       clear,
  input  logic       decrement,
  output logic [7:0] count,
  output logic       expired
);

  logic [7:0] count_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q <= 8'd0;
    end else if (clear) begin
      count_q <= 8'd0;
    end else if (load) begin
      count_q <= INIT;
    end else if (decrement && (count_q != 8'd0)) begin
      count_q <= count_q - 8'd1;
    end
  end

  assign count   = count_q;
  assign expired = (count_q == 8'd0);

endmodule

// File: rtl/round_referee.sv
// Judges each game round and emits one-cycle verdict pulses to the game state machine.
// Define ROUND_TIMEOUT_EN to enable the per-round frame budget and timeout loss.
module round_referee
  import game_pkg::*;
#(
  parameter logic [9:0] GOAL_X       = GOAL_X_DEF,
  parameter logic [2:0] HOLD_FRAMES  = HOLD_FRAMES_DEF,
  parameter logic [7:0] ROUND_FRAMES = ROUND_FRAMES_DEF
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [5:0] state,
  input  logic       frame_tick,
  input  logic       enemy_overlap,
  input  logic [9:0] player_x,
  output logic       wonFirstRound,
  output logic       wonSecondRound,
  output logic       wonThirdRound,
  output logic       wonFourthRound,
  output logic       collidedWithEnemy,
  output logic [7:0] frames_left
);

  logic [1:0] fsm_q, fsm_d;
  logic [5:0] prev_state_q;
  logic [2:0] hold_q, hold_d, hold_inc;
  logic       hit_q, hit_d, hit_now;
  logic [3:0] won_q, won_d;
  logic       coll_q, coll_d;
  logic       timer_load, timer_dec, timer_clr, expired, ended;
  logic       state_changed, enter_round;

  assign state_changed = (state != prev_state_q);
  assign enter_round   = state_changed && is_round_state(state);
  assign hit_now       = hit_q | enemy_overlap;
  assign hold_inc      = (hold_q == 3'd7) ? 3'd7 : hold_q + 3'd1;

  always_comb begin
    fsm_d      = fsm_q;
    hold_d     = hold_q;
    hit_d      = hit_q;
    won_d      = 4'b0000;
    coll_d     = 1'b0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    ended      = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (enter_round) begin
          fsm_d      = PLAY;
          timer_load = 1'b1;
          hold_d     = 3'd0;
          hit_d      = 1'b0;
        end
      end
      PLAY: begin
        if (enter_round) begin
          timer_load = 1'b1;
          hold_d     = 3'd0;
          hit_d      = 1'b0;
        end else if (state_changed) begin
          fsm_d  = IDLE;
          hold_d = 3'd0;
          hit_d  = 1'b0;
        end else begin
          hit_d = hit_now;
          if (frame_tick) begin
            hit_d = 1'b0;
            if (hit_now) begin
              coll_d = 1'b1;
              ended  = 1'b1;
            end else if (player_x >= GOAL_X) begin
              hold_d = hold_inc;
              if (hold_inc == HOLD_FRAMES) begin
                won_d = {state == FIN, state == THIRD, state == SECOND, state == FIRST};
                ended = 1'b1;
              end
            end else begin
              hold_d = 3'd0;
            end
            // Timeout only counts if neither collision nor goal already decided the round.
            if (!ended) begin
              if (expired) begin
                coll_d = 1'b1;
                ended  = 1'b1;
              end else begin
                timer_dec = 1'b1;
              end
            end
            if (ended) fsm_d = DONE;
          end
        end
      end
      DONE: begin
        if (enter_round) begin
          fsm_d      = PLAY;
          timer_load = 1'b1;
          hold_d     = 3'd0;
          hit_d      = 1'b0;
        end else if (state_changed) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign timer_clr = (fsm_d == IDLE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fsm_q        <= IDLE;
      prev_state_q <= INI;
      hold_q       <= 3'd0;
      hit_q        <= 1'b0;
      won_q        <= 4'b0000;
      coll_q       <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      prev_state_q <= state;
      hold_q       <= hold_d;
      hit_q        <= hit_d;
      won_q        <= won_d;
      coll_q       <= coll_d;
    end
  end

`ifdef ROUND_TIMEOUT_EN
  round_timer #(
    .INIT(ROUND_FRAMES)
  ) u_round_timer (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .load     (timer_load),
    .clear    (timer_clr),
    .decrement(timer_dec),
    .count    (frames_left),
    .expired  (expired)
  );
`else
  logic unused_timer;
  assign unused_timer = ^{timer_load, timer_dec, timer_clr, ROUND_FRAMES};
  assign frames_left  = 8'd0;
  assign expired      = 1'b0;
`endif

  assign wonFirstRound     = won_q[0];
  assign wonSecondRound    = won_q[1];
  assign wonThirdRound     = won_q[2];
  assign wonFourthRound    = won_q[3];
  assign collidedWithEnemy = coll_q;

endmodule
